// File: rtl/sym_frame_pkg.sv
// Shared types and constants for the symbol frame sender.
// Feature macro used by the sender: SYM_FRAME_SENDER_TIMEOUT_EN.
package sym_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [2:0] SYM_FS  = 3'd0;
    localparam logic [2:0] SYM_CH  = 3'd1;
    localparam logic [2:0] SYM_X0  = 3'd2;
    localparam logic [2:0] SYM_DIR = 3'd3;
    localparam logic [2:0] SYM_FE  = 3'd4;

    localparam int TMO_W = 16;

    // Bit positions inside the packed strobe vector {Fs, One, Zero, X0, Fe}
    localparam int STB_FS   = 4;
    localparam int STB_ONE  = 3;
    localparam int STB_ZERO = 2;
    localparam int STB_X0   = 1;
    localparam int STB_FE   = 0;

    function automatic logic [4:0] sym_onehot(input logic [2:0] idx,
                                              input logic       ch,
                                              input logic       dir);
        logic [4:0] v;
        v = '0;
        case (idx)
            SYM_FS:  v[STB_FS] = 1'b1;
            SYM_CH:  if (ch) v[STB_ONE] = 1'b1; else v[STB_ZERO] = 1'b1;
            SYM_X0:  v[STB_X0] = 1'b1;
            SYM_DIR: if (dir) v[STB_ONE] = 1'b1; else v[STB_ZERO] = 1'b1;
            SYM_FE:  v[STB_FE] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sym_frame_sender_sync2.sv
// Two-flop synchroniser for one asynchronous ack line.
// Feature macro SYM_FRAME_SENDER_TIMEOUT_EN has no effect here.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sym_frame_sender.sv
// Sends the five-symbol frame Fs, ch, X0, dir, Fe with a four-phase handshake per symbol.
// Define SYM_FRAME_SENDER_TIMEOUT_EN to build the ack timeout and sticky err flag.
module sym_frame_sender
    import sym_frame_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_channel,
    input  logic cmd_dir,
    output logic Fs,
    output logic X0,
    output logic Fe,
    output logic One,
    output logic Zero,
    input  logic Fs_ack,
    input  logic X0_ack,
    input  logic Fe_ack,
    input  logic one_ack,
    input  logic zero_ack,
    output logic done,
    output logic err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic             r_ch;
    logic             r_dir;
    logic [4:0]       r_strobe;
    logic [GAP_W-1:0] r_gap;

    logic w_fs_s, w_x0_s, w_fe_s, w_one_s, w_zero_s;
    logic w_ack_match;
    logic w_done;

    sync2 u_sync_fs   (.clk(clk), .rst_n(rst_n), .d(Fs_ack),   .q(w_fs_s));
    sync2 u_sync_x0   (.clk(clk), .rst_n(rst_n), .d(X0_ack),   .q(w_x0_s));
    sync2 u_sync_fe   (.clk(clk), .rst_n(rst_n), .d(Fe_ack),   .q(w_fe_s));
    sync2 u_sync_one  (.clk(clk), .rst_n(rst_n), .d(one_ack),  .q(w_one_s));
    sync2 u_sync_zero (.clk(clk), .rst_n(rst_n), .d(zero_ack), .q(w_zero_s));

    // Only the ack belonging to the symbol in flight is ever looked at.
    always_comb begin
        w_ack_match = 1'b0;
        case (r_idx)
            SYM_FS:  w_ack_match = w_fs_s;
            SYM_CH:  w_ack_match = r_ch ? w_one_s : w_zero_s;
            SYM_X0:  w_ack_match = w_x0_s;
            SYM_DIR: w_ack_match = r_dir ? w_one_s : w_zero_s;
            SYM_FE:  w_ack_match = w_fe_s;
            default: w_ack_match = 1'b0;
        endcase
    end

`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             w_tmo_hit;
    assign w_tmo_hit = (r_tmo >= TMO_LIMIT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= SYM_FS;
            r_ch     <= 1'b0;
            r_dir    <= 1'b0;
            r_strobe <= '0;
            r_gap    <= '0;
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
            r_tmo    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_ch     <= cmd_channel;
                        r_dir    <= cmd_dir;
                        r_idx    <= SYM_FS;
                        r_strobe <= sym_onehot(SYM_FS, cmd_channel, cmd_dir);
                        r_state  <= DRIVE;
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
                        r_tmo    <= TMO_W'(1);
                        r_err    <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    if (w_ack_match) begin
                        r_strobe <= '0;
                        r_state  <= RELEASE;
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
                        r_tmo    <= TMO_W'(1);
                    end else if (w_tmo_hit) begin
                        r_strobe <= '0;
                        r_err    <= 1'b0 | 1'b1;
                        r_state  <= IDLE;
                    end else if (r_tmo != '1) begin
                        r_tmo    <= r_tmo + TMO_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (!w_ack_match) begin
                        if (r_idx == SYM_FE) begin
                            r_state <= IDLE;
                        end else if (GAP_CYCLES == 0) begin
                            r_idx    <= r_idx + 3'd1;
                            r_strobe <= sym_onehot(r_idx + 3'd1, r_ch, r_dir);
                            r_state  <= DRIVE;
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
                            r_tmo    <= TMO_W'(1);
`endif
                        end else begin
                            r_gap   <= GAP_LOAD;
                            r_state <= GAP;
                        end
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_tmo != '1) begin
                        r_tmo   <= r_tmo + TMO_W'(1);
`endif
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        r_idx    <= r_idx + 3'd1;
                        r_strobe <= sym_onehot(r_idx + 3'd1, r_ch, r_dir);
                        r_state  <= DRIVE;
`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
                        r_tmo    <= TMO_W'(1);
`endif
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_strobe <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // done is decoded from registered state and the synchronised ack, so it
    // pulses in the last RELEASE cycle, one cycle before cmd_ready returns.
    assign w_done = (r_state == RELEASE) && (r_idx == SYM_FE) && !w_ack_match;

    assign cmd_ready = (r_state == IDLE);
    assign done      = w_done;
    assign Fs        = r_strobe[STB_FS];
    assign One       = r_strobe[STB_ONE];
    assign Zero      = r_strobe[STB_ZERO];
    assign X0        = r_strobe[STB_X0];
    assign Fe        = r_strobe[STB_FE];

`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sym_frame_sender.sv
// Scoreboard bench for sym_frame_sender; the timeout scenario follows SYM_FRAME_SENDER_TIMEOUT_EN.
module tb_sym_frame_sender;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_channel = 1'b0;
    logic cmd_dir = 1'b0;
    logic cmd_ready;
    logic Fs, X0, Fe, One, Zero;
    logic Fs_ack, X0_ack, Fe_ack, one_ack, zero_ack;
    logic done, err;

    always #5 clk = ~clk;

    sym_frame_sender #(.ACK_TIMEOUT(10), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_channel(cmd_channel), .cmd_dir(cmd_dir),
        .Fs(Fs), .X0(X0), .Fe(Fe), .One(One), .Zero(Zero),
        .Fs_ack(Fs_ack), .X0_ack(X0_ack), .Fe_ack(Fe_ack),
        .one_ack(one_ack), .zero_ack(zero_ack),
        .done(done), .err(err)
    );

    // Responder: ack follows strobe after resp_delay cycles (0 = combinational).
    logic       resp_en = 1'b0;
    int         resp_delay = 0;
    logic       zero_force = 1'b0;
    logic [4:0] strb;
    logic [4:0] hist [0:7];
    logic [4:0] resp;

    assign strb = {Fs, One, Zero, X0, Fe};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
        end else begin
            for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= strb;
        end
    end

    always_comb begin
        resp = '0;
        if (resp_en) resp = (resp_delay == 0) ? strb : hist[resp_delay-1];
    end

    assign Fs_ack   = resp[4];
    assign one_ack  = resp[3];
    assign zero_ack = resp[2] | zero_force;
    assign X0_ack   = resp[1];
    assign Fe_ack   = resp[0];

    // Scoreboard
    typedef struct { int code; int rel; } exp_t;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    int   done_cnt = 0;
    int   fs_hi_cnt = 0;
    int   multi_hot_cnt = 0;
    logic [4:0] prev_strb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sym_name(input int c);
        case (c)
            4: return "Fs";
            3: return "One";
            2: return "Zero";
            1: return "X0";
            0: return "Fe";
            5: return "done";
            default: return "none";
        endcase
    endfunction

    task automatic check_event(input int c);
        int   rel;
        exp_t e;
        rel = cyc - acc_edge + 1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", sym_name(c), rel);
        end else begin
            e = exp_q.pop_front();
            if (e.code != c || (e.rel >= 0 && e.rel != rel)) begin
                miscompares++;
                $display("FAIL symbol_seq: got %s at cycle %0d, required %s at cycle %0d",
                         sym_name(c), rel, sym_name(e.code), e.rel);
            end
        end
    endtask

    always @(negedge clk) begin
        if ($countones(strb) > 1) multi_hot_cnt <= multi_hot_cnt + 1;
        if (strb[4]) fs_hi_cnt <= fs_hi_cnt + 1;
        for (int b = 4; b >= 0; b--)
            if (strb[b] && !prev_strb[b]) check_event(b);
        if (done) begin
            check_event(5);
            done_cnt <= done_cnt + 1;
        end
        prev_strb = strb;
    end

    task automatic check(input string nm, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // mode 0: full frame with cycle-exact times; 1: full frame, order only; 2: Fs only
    task automatic send(input logic ch, input logic dir, input int mode);
        int t [0:5];
        int c [0:5];
        int n;
        c[0] = 4; c[1] = ch ? 3 : 2; c[2] = 1; c[3] = dir ? 3 : 2; c[4] = 0; c[5] = 5;
        t[0] = 1; t[1] = 9; t[2] = 17; t[3] = 25; t[4] = 33; t[5] = 38;
        n = (mode == 2) ? 1 : 6;
        @(negedge clk);
        for (int i = 0; i < n; i++) exp_q.push_back('{c[i], (mode == 0) ? t[i] : -1});
        cmd_valid   = 1'b1;
        cmd_channel = ch;
        cmd_dir     = dir;
        acc_edge    = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int base, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > base) break;
        end
        vectors++;
        if (done_cnt <= base) begin
            miscompares++;
            $display("FAIL %s: got no done within %0d cycles, required done", nm, budget);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fs_base;
        int mh_base;
        bit found;

        // Reset and idle
        repeat (3) @(negedge clk);
        #1;
        check("reset_strobes", int'(strb), 0);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_err", int'(err), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("idle_strobes", int'(strb), 0);

        // ch=1 dir=1, zero-delay responder, exact timing
        resp_en = 1'b1; resp_delay = 0;
        base = done_cnt; fs_base = fs_hi_cnt; mh_base = multi_hot_cnt;
        send(1'b1, 1'b1, 0);
        wait_done("frame11_done", base, 60);
        check("frame11_ready_at_done", int'(cmd_ready), 0);
        @(negedge clk); #1;
        check("frame11_ready_after", int'(cmd_ready), 1);
        check("frame11_fs_high_cycles", fs_hi_cnt - fs_base, 3);
        check("frame11_queue_left", exp_q.size(), 0);

        // ch=0 dir=0, 5-cycle responder, plus an ignored cmd_valid mid-frame
        resp_delay = 5;
        base = done_cnt; fs_base = fs_hi_cnt;
        send(1'b0, 1'b0, 1);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1; cmd_channel = 1'b1; cmd_dir = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("frame00_done", base, 300);
        repeat (20) @(negedge clk);
        #1;
        check("frame00_fs_high_cycles", fs_hi_cnt - fs_base, 8);
        check("frame00_queue_left", exp_q.size(), 0);
        check("frame00_one_hot", multi_hot_cnt - mh_base, 0);

        // Wrong ack on zero_ack while Fs waits
        resp_en = 1'b0; resp_delay = 0;
        base = done_cnt;
        send(1'b1, 1'b0, 1);
        zero_force = 1'b1;
        repeat (2) @(negedge clk);
        zero_force = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("wrong_ack_strobes", int'(strb), 16);
        resp_en = 1'b1;
        wait_done("wrong_ack_done", base, 100);

        // Reset while X0 is driven
        repeat (3) @(negedge clk);
        send(1'b0, 1'b1, 1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (X0) begin found = 1; break; end
        end
        check("reset_mid_x0_seen", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_strobes", int'(strb), 0);
        check("reset_mid_ready", int'(cmd_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("reset_mid_after_strobes", int'(strb), 0);
        check("reset_mid_after_ready", int'(cmd_ready), 1);

`ifdef SYM_FRAME_SENDER_TIMEOUT_EN
        // Fs never acked: abort after 10 cycles
        resp_en = 1'b0;
        base = done_cnt; fs_base = fs_hi_cnt;
        send(1'b1, 1'b1, 2);
        repeat (14) @(negedge clk);
        #1;
        check("tmo_fs_high_cycles", fs_hi_cnt - fs_base, 10);
        check("tmo_strobes", int'(strb), 0);
        check("tmo_err", int'(err), 1);
        check("tmo_ready", int'(cmd_ready), 1);
        check("tmo_no_done", done_cnt - base, 0);
        resp_en = 1'b1;
        base = done_cnt;
        send(1'b1, 1'b1, 0);
        #1;
        check("tmo_err_cleared", int'(err), 0);
        wait_done("tmo_next_done", base, 60);
`else
        // Without the timeout the sender waits on Fs indefinitely
        resp_en = 1'b0;
        base = done_cnt;
        send(1'b1, 1'b1, 1);
        repeat (30) @(negedge clk);
        #1;
        check("wait_fs_held", int'(Fs), 1);
        check("wait_err", int'(err), 0);
        resp_en = 1'b1;
        wait_done("wait_done", base, 100);
`endif
        repeat (5) @(negedge clk);
        #1;
        check("final_queue_left", exp_q.size(), 0);
        check("final_one_hot", multi_hot_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sym_frame_sender.md
# sym_frame_sender

Upstream send-side stage that turns a one-shot channel/direction command into the five-symbol frame consumed by the channel-output decoder. The frame is Fs, channel symbol, X0, direction symbol, Fe. Each symbol is one strobe line driven with a four-phase req/ack handshake against that symbol's ack line. The block sits between command/control logic and the decoder, and owns all symbol sequencing and ack synchronisation.

## Interface
Parameters:
- ACK_TIMEOUT, 255: max cycles waited in either handshake phase before abort; legal range 1..65535.
- GAP_CYCLES, 2: idle cycles inserted between symbols; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_channel  in  1  0 → Zero symbol after Fs; 1 → One symbol
- cmd_dir  in  1  1 (up) → One symbol after X0; 0 (down) → Zero symbol
- Fs, X0, Fe, One, Zero  out  1 each  symbol strobes, registered
- Fs_ack, X0_ack, Fe_ack, one_ack, zero_ack  in  1 each  asynchronous acks
- done  out  1  one-cycle pulse when a frame completes
- err  out  1  sticky timeout flag

## Operation
- Reset values: all strobes 0, done 0, err 0, cmd_ready 1, state IDLE.
- When reset asserts mid-frame, all strobes drop immediately and the in-flight command is discarded. No Fe is sent.
- Acceptance:
  - cmd_channel and cmd_dir are captured on acceptance.
  - Symbol index 0..4 selects Fs, ch-sym, X0, dir-sym, Fe.
- FSM states: IDLE, DRIVE, RELEASE, GAP.
  - IDLE: on accept, go to DRIVE with idx = 0.
  - DRIVE: the strobe for idx is high. Only the matching synchronised ack is observed. When it is seen high, drop the strobe and go to RELEASE.
  - RELEASE: wait for the matching ack_s low.
    - If idx = 4: pulse done and go to IDLE.
    - Else if GAP_CYCLES = 0: go to DRIVE with idx + 1.
    - Else: go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to DRIVE with idx + 1.
- Ack handling:
  - Non-matching acks are ignored in all states.
  - An ack already high when DRIVE is entered counts as seen. The responder is required to have released it.
- Invariants:
  - At most one strobe is high in any cycle.
  - A strobe never re-rises until its ack_s has been seen low.
- cmd_valid while not ready is ignored, not queued.
- err clears on the next accepted command.

## Timing
- Strobes assert the cycle after the accept edge (registered).
- Each ack passes through a 2-flop synchroniser, so 2 cycles of latency before the FSM sees it.
- With a zero-delay responder (ack = strobe):
  - strobe high for 3 cycles, low phase 3 cycles;
  - symbol rise-to-rise period is 6 + GAP_CYCLES;
  - full frame with GAP_CYCLES = 2: accept at cycle 0, Fs rises at 1, Fe rises at 33, done at 38, cmd_ready high at 39.
- The timeout counter restarts on every entry to DRIVE and RELEASE. It is 16 bits wide and saturates.

## Configuration
- Macro SYM_FRAME_SENDER_TIMEOUT_EN.
- Defined:
  - If the counter reaches ACK_TIMEOUT in DRIVE or RELEASE, all strobes drop next cycle and err sets.
  - The FSM goes to IDLE and cmd_ready rises that same cycle. No done pulse.
- Undefined:
  - No counter is built. The FSM waits indefinitely and err is tied 0.

## Structure
- Shared package sym_frame_pkg:
  - state enum: IDLE, DRIVE, RELEASE, GAP;
  - symbol index constants SYM_FS = 0, SYM_CH = 1, SYM_X0 = 2, SYM_DIR = 3, SYM_FE = 4;
  - timeout counter width constant.
- One sub-module: sync2, a 2-flop synchroniser with async active-low reset. Instantiated five times, once per ack.

## Test plan
- Reset then idle: rst_n low → all strobes 0, cmd_ready 1, err 0; no strobe activity while cmd_valid = 0.
- Frame ch=1, dir=1 with zero-delay responder, GAP_CYCLES = 2:
  - strobe order is Fs, One, X0, One, Fe;
  - Fs rises at cycle 1, Fe at cycle 33, done at 38.
- Frame ch=0, dir=0 with 5-cycle responder delay:
  - order is Fs, Zero, X0, Zero, Fe;
  - each strobe stays high until its ack_s is seen;
  - never two strobes high at once.
- Wrong ack: zero_ack pulses while Fs is driven → ignored; Fs stays high until Fs_ack arrives.
- Reset mid-frame: rst_n low during X0 DRIVE → X0 drops asynchronously; after release, IDLE with cmd_ready 1 and no Fe.
- Timeout (macro defined, ACK_TIMEOUT = 10): responder never acks Fs → Fs drops after 10 cycles, err = 1, cmd_ready = 1; the next accept clears err.
